// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM states,
// the NOP encoding and the default PC increment.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic [31:0] NOP         = 32'b0;
  localparam int          PC_STEP_DEF = 4;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response channel between the fetch
// controller (master) and the instruction memory (slave).
interface if_fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic [31:0]       rdata;

  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the imem req/ready handshake and
// drives freeze/flush of the IF/ID register so ID sees each instruction once.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = PC_STEP_DEF,
  parameter int                CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 branch_taken,
  input  logic [ADDR_W-1:0]    branch_addr,
  input  logic                 hazard_freeze,
  input  logic                 mem_freeze,
  if_fetch_ctrl_if.master      imem,
  output logic [ADDR_W-1:0]    pc_out,
  output logic [31:0]          instr_out,
  output logic                 if_reg_freeze,
  output logic                 if_reg_flush,
  output logic [CNT_W-1:0]     bubble_cnt
);

  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t              state_reg;
  logic [ADDR_W-1:0]   pc_reg;
  logic [ADDR_W-1:0]   drop_addr_reg;
  logic [ADDR_W-1:0]   buf_pc_reg;
  logic [31:0]         buf_instr_reg;
  logic [CNT_W-1:0]    bubble_cnt_reg;

  logic stall;
  logic br;
  logic flush_int;

  assign stall = hazard_freeze | mem_freeze;
  // A frozen EX stage will re-assert its redirect, so ignore it meanwhile.
  assign br    = branch_taken & ~mem_freeze;

  always_comb begin
    imem.req      = 1'b0;
    imem.addr     = pc_reg;
    pc_out        = pc_reg + STEP;
    instr_out     = imem.rdata;
    if_reg_freeze = 1'b0;
    flush_int     = 1'b0;
    case (state_reg)
      FETCH: begin
        imem.req = 1'b1;
        if (br) begin
          flush_int = 1'b1;
        end else if (imem.ready) begin
          if_reg_freeze = stall;
        end else begin
          flush_int     = ~stall;
          if_reg_freeze = stall;
        end
      end
      HOLD: begin
        pc_out    = buf_pc_reg;
        instr_out = buf_instr_reg;
        if (br) flush_int = 1'b1;
        else    if_reg_freeze = stall;
      end
      DROP: begin
        // The pending request keeps its original address until it completes.
        imem.req  = 1'b1;
        imem.addr = drop_addr_reg;
        instr_out = NOP;
        if (br) begin
          flush_int = 1'b1;
        end else begin
          flush_int     = ~stall;
          if_reg_freeze = stall;
        end
      end
      default: ;
    endcase
    if (rst) begin
      imem.req      = 1'b0;
      imem.addr     = RESET_PC;
      pc_out        = '0;
      instr_out     = '0;
      if_reg_freeze = 1'b0;
      flush_int     = 1'b1;
    end
  end

  assign if_reg_flush = flush_int;
  assign bubble_cnt   = bubble_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      drop_addr_reg  <= RESET_PC;
      buf_pc_reg     <= '0;
      buf_instr_reg  <= NOP;
      bubble_cnt_reg <= '0;
    end else begin
      if (flush_int && bubble_cnt_reg != CNT_MAX)
        bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
      case (state_reg)
        FETCH: begin
          if (br) begin
            pc_reg <= branch_addr;
            if (!imem.ready) begin
              state_reg     <= DROP;
              drop_addr_reg <= pc_reg;
            end
          end else if (imem.ready) begin
            if (stall) begin
              buf_instr_reg <= imem.rdata;
              buf_pc_reg    <= pc_reg + STEP;
              state_reg     <= HOLD;
            end else begin
              pc_reg <= pc_reg + STEP;
            end
          end
        end
        HOLD: begin
          if (br) begin
            pc_reg    <= branch_addr;
            state_reg <= FETCH;
          end else if (!stall) begin
            pc_reg    <= pc_reg + STEP;
            state_reg <= FETCH;
          end
        end
        DROP: begin
          if (br)         pc_reg    <= branch_addr;
          if (imem.ready) state_reg <= FETCH;
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Sequences instruction fetch from a variable-latency instruction memory using a req/ready handshake, and owns the PC register.
- Drives the freeze/flush controls of the IF/ID pipeline register, so that ID sees exactly one copy of each instruction or a NOP bubble.
- Arbitrates between three sources: memory wait, pipeline stalls (hazard, data-memory) and branch redirects from EX.
- Sits between the instruction memory, the IF/ID register and the hazard unit.

Parameters:
- ADDR_W, 32, PC/address width.
- RESET_PC, 0, PC value after reset.
- PC_STEP, 4, PC increment per instruction.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- branch_taken  in  1  EX-stage redirect request.
- branch_addr  in  ADDR_W  redirect target.
- hazard_freeze  in  1  ID hazard stall.
- mem_freeze  in  1  global stall from data memory.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  response valid; completes the request.
- imem_rdata  in  32  fetched instruction.
- pc_out  out  ADDR_W  fetched PC + PC_STEP, to the IF/ID register.
- instr_out  out  32  instruction to the IF/ID register.
- if_reg_freeze  out  1  hold the IF/ID register.
- if_reg_flush  out  1  load a NOP into the IF/ID register (priority over freeze).
- bubble_cnt  out  CNT_W  count of flush-bubbles inserted; saturates.

Behaviour:
- Definition: stall = hazard_freeze | mem_freeze.
- State register: FETCH, HOLD, DROP.
- Reset cycle:
  - pc=RESET_PC, state=FETCH, bubble_cnt=0.
  - Outputs during rst: imem_req=0, imem_addr=RESET_PC, pc_out=0, instr_out=0, if_reg_freeze=0, if_reg_flush=1.
  - Any outstanding memory request is abandoned; the memory must tolerate this.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - ready=1, stall=0: IF/ID loads imem_rdata and pc+PC_STEP (freeze=0, flush=0); pc advances by PC_STEP; remain in FETCH.
  - Back-to-back: req stays high and imem_addr changes the next cycle. A zero-wait memory therefore gives 1 instruction/cycle.
  - ready=1, stall=1: capture rdata and pc into the hold buffer; freeze=1; go to HOLD.
  - ready=0, stall=0: flush=1 (bubble); bubble_cnt increments.
  - ready=0, stall=1: freeze=1, flush=0.
- HOLD:
  - imem_req=0; instr_out and pc_out are driven from the buffer; freeze=1 while stall=1.
  - When stall=0: IF/ID loads the buffer; pc advances; go to FETCH.
- DROP:
  - imem_req=1 with the old address until ready. The response is discarded; flush=1 each cycle unless stall.
  - On ready: go to FETCH at the redirected pc.
- Branch (branch_taken=1 and mem_freeze=0):
  - Same cycle: pc<=branch_addr and if_reg_flush=1.
  - Branch beats hazard_freeze.
  - From FETCH with ready=0: go to DROP. Address change is forbidden mid-request.
  - From FETCH with ready=1: discard rdata; go to FETCH.
  - From HOLD: discard the buffer; go to FETCH.
  - From DROP: update pc only; stay in DROP.
- If mem_freeze=1: branch_taken is ignored. EX is frozen and re-asserts it.
- Flush cycles caused by branch also increment bubble_cnt.
- bubble_cnt holds at all-ones.
- pc wraps modulo 2^ADDR_W.

Decomposition:
- Shared package if_pkg holds:
  - The state enum.
  - The NOP encoding (32'b0).
  - The PC_STEP default.
- Flat implementation; no sub-module is warranted. The pc/hold buffer registers stay inline.

Test Plan:
- Zero-wait memory (ready tied 1), RESET_PC=0, no stalls: imem_addr reads 0,4,8,12 on consecutive cycles. pc_out reads 4,8,12,16 with no flush. bubble_cnt=0.
- Memory with 2 wait cycles at addr 0: imem_addr holds 0 for 3 cycles and flush=1 for 2 cycles. bubble_cnt=2; instruction loads on the third cycle.
- hazard_freeze high for 3 cycles while ready returns instr 0xE3A01005: state goes to HOLD and imem_req=0. Freeze=1 for 3 cycles, then the IF/ID register loads 0xE3A01005 exactly once.
- Branch to 0x100 while a request at 0x8 is waiting:
  - Same cycle: flush=1.
  - imem_addr stays 0x8 until ready; the response is discarded.
  - Next request is at 0x100.
- Branch with mem_freeze=1: pc unchanged and no flush. Branch re-asserted after the freeze drops takes effect.
- rst asserted while in DROP: next cycle state=FETCH and imem_addr=RESET_PC. bubble_cnt=0; imem_req=1 from the first post-reset cycle.
